// File: rtl/systolic_feeder_8x8.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder_8x8
// Purpose  : Accepts K-slices of A/B, applies the diagonal skew, drives and
//            flushes an 8x8 output-stationary systolic array.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder_8x8 #(
  parameter int data_width = 8,
  parameter int kw         = 8
) (
  input  logic                    clk_buf,
  input  logic                    rst,
  input  logic                    start,
  input  logic [kw-1:0]           k_len,
  output logic                    busy,
  output logic                    arr_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*data_width-1:0] a_vec,
  input  logic [8*data_width-1:0] b_vec,
  output logic [8*data_width-1:0] a_in_flat,
  output logic [8*data_width-1:0] b_in_flat,
  output logic                    en,
  output logic                    done
);

  localparam int         LANES       = 8;
  localparam logic [3:0] C_FLUSH_MAX = 4'(2 * (LANES - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [kw-1:0]           r_remain;
  logic [3:0]              r_flush_cnt;
  logic                    r_arr_clr;
  logic                    r_en;
  logic                    w_step;
  logic                    w_feed;
  logic [8*data_width-1:0] w_a_src;
  logic [8*data_width-1:0] w_b_src;

  assign w_feed  = (r_state == S_FEED);
  // FLUSH spends one extra non-stepping cycle so the last en beat lands in C before done.
  assign w_step  = (w_feed && in_valid) ||
                   ((r_state == S_FLUSH) && (r_flush_cnt != C_FLUSH_MAX));
  assign w_a_src = w_feed ? a_vec : '0;
  assign w_b_src = w_feed ? b_vec : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (k_len != '0) ? S_FEED : S_DONE;
      S_FEED:  if (in_valid && (r_remain == kw'(1))) w_next = S_FLUSH;
      S_FLUSH: if (r_flush_cnt == C_FLUSH_MAX) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_buf or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remain    <= '0;
      r_flush_cnt <= '0;
      r_arr_clr   <= 1'b0;
      r_en        <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_arr_clr <= (r_state == S_IDLE) && start && (k_len != '0);
      r_en      <= w_step;
      if ((r_state == S_IDLE) && start)
        r_remain <= k_len;
      else if (w_feed && in_valid)
        r_remain <= r_remain - kw'(1);
      if (r_state == S_FLUSH)
        r_flush_cnt <= r_flush_cnt + 4'd1;
      else
        r_flush_cnt <= '0;
    end
  end

  // Lane i: i delay stages followed by the output register, all advanced on step.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [data_width-1:0] r_a_out;
    logic [data_width-1:0] r_b_out;

    if (i == 0) begin : g_direct
      always_ff @(posedge clk_buf or posedge rst) begin
        if (rst) begin
          r_a_out <= '0;
          r_b_out <= '0;
        end else if (w_step) begin
          r_a_out <= w_a_src[0 +: data_width];
          r_b_out <= w_b_src[0 +: data_width];
        end
      end
    end else begin : g_delay
      logic [data_width-1:0] r_a_sr [i];
      logic [data_width-1:0] r_b_sr [i];

      always_ff @(posedge clk_buf or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < i; j++) begin
            r_a_sr[j] <= '0;
            r_b_sr[j] <= '0;
          end
          r_a_out <= '0;
          r_b_out <= '0;
        end else if (w_step) begin
          r_a_sr[0] <= w_a_src[i*data_width +: data_width];
          r_b_sr[0] <= w_b_src[i*data_width +: data_width];
          for (int j = 1; j < i; j++) begin
            r_a_sr[j] <= r_a_sr[j-1];
            r_b_sr[j] <= r_b_sr[j-1];
          end
          r_a_out <= r_a_sr[i-1];
          r_b_out <= r_b_sr[i-1];
        end
      end
    end

    assign a_in_flat[i*data_width +: data_width] = r_a_out;
    assign b_in_flat[i*data_width +: data_width] = r_b_out;
  end

  assign busy     = (r_state != S_IDLE);
  assign in_ready = w_feed;
  assign done     = (r_state == S_DONE);
  assign arr_clr  = r_arr_clr;
  assign en       = r_en;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder_8x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder_8x8
// Purpose  : Self-checking bench; drives jobs, models the 8x8 array and
//            compares C against a direct matrix product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder_8x8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  k_len;
  logic        busy;
  logic        arr_clr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_vec;
  logic [63:0] b_vec;
  logic [63:0] a_in_flat;
  logic [63:0] b_in_flat;
  logic        en;
  logic        done;

  systolic_feeder_8x8 #(.data_width(8), .kw(8)) dut (
    .clk_buf   (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .arr_clr   (arr_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .a_in_flat (a_in_flat),
    .b_in_flat (b_in_flat),
    .en        (en),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output-stationary 8x8 array: A flows right, B flows down, acc += a*b on en.
  logic [31:0] acc  [8][8];
  logic [7:0]  a_pp [8][8];
  logic [7:0]  b_pp [8][8];

  always @(posedge clk or posedge rst) begin : array_model
    logic [7:0] ta;
    logic [7:0] tb;
    if (rst || arr_clr) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          acc[r][c]  <= '0;
          a_pp[r][c] <= '0;
          b_pp[r][c] <= '0;
        end
    end else if (en) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          ta = (c == 0) ? a_in_flat[r*8 +: 8] : a_pp[r][c-1];
          tb = (r == 0) ? b_in_flat[c*8 +: 8] : b_pp[r-1][c];
          acc[r][c]  <= acc[r][c] + ta * tb;
          a_pp[r][c] <= ta;
          b_pp[r][c] <= tb;
        end
    end
  end

  logic [7:0] ma [8][256];   // A[r][k]
  logic [7:0] mb [256][8];   // B[k][c]

  typedef struct {
    int k;
    int stall;     // 0 none, 1 alternate, 2 random
    int glitch;    // hold start high throughout the job
    int fill;      // 0 ramp 1..8, 1 random, 2 all 8'hFF
    int exp_en;
    int exp_done;  // cycles after start; -1 when stalls make it data dependent
  } job_t;

  task automatic run_job(input job_t j, input int id);
    int t, beat, en_cnt, last_en, done_t, clr_cnt, rdy_cnt;
    int a_nz_cnt [8];
    int a_nz_idx [8];
    int b_nz_cnt [8];
    int b_nz_idx [8];
    logic v;
    logic [31:0] s;
    for (int r = 0; r < 8; r++) begin
      a_nz_cnt[r] = 0; a_nz_idx[r] = -1; b_nz_cnt[r] = 0; b_nz_idx[r] = -1;
      for (int kk = 0; kk < j.k; kk++) begin
        case (j.fill)
          0:       begin ma[r][kk] = 8'(r + 1); mb[kk][r] = 8'(r + 1); end
          1:       begin ma[r][kk] = 8'($urandom); mb[kk][r] = 8'($urandom); end
          default: begin ma[r][kk] = 8'hFF; mb[kk][r] = 8'hFF; end
        endcase
      end
    end
    start = 1'b1; k_len = 8'(j.k); in_valid = 1'b0;
    tick();
    start = 1'b0;
    t = 1; beat = 0; en_cnt = 0; last_en = -1; done_t = -1; clr_cnt = 0; rdy_cnt = 0;
    while (done_t < 0 && t < 3000) begin
      if (en) begin
        for (int r = 0; r < 8; r++) begin
          if (a_in_flat[r*8 +: 8] != 8'd0) begin a_nz_cnt[r]++; a_nz_idx[r] = en_cnt; end
          if (b_in_flat[r*8 +: 8] != 8'd0) begin b_nz_cnt[r]++; b_nz_idx[r] = en_cnt; end
        end
        en_cnt++;
        last_en = t;
      end
      if (arr_clr)  clr_cnt++;
      if (in_ready) rdy_cnt++;
      if (done)     done_t = t;
      if (in_ready && beat < j.k) begin
        v = (j.stall == 0) ? 1'b1 : (j.stall == 1) ? 1'((t % 2) == 1) : 1'($urandom_range(0, 1));
        in_valid = v;
        if (v) begin
          for (int r = 0; r < 8; r++) begin
            a_vec[r*8 +: 8] = ma[r][beat];
            b_vec[r*8 +: 8] = mb[beat][r];
          end
          beat++;
        end else begin
          a_vec = {$urandom, $urandom};
          b_vec = {$urandom, $urandom};
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        a_vec = {$urandom, $urandom};
        b_vec = {$urandom, $urandom};
      end
      start = (j.glitch != 0);
      if (j.glitch != 0) k_len = 8'($urandom_range(1, 255));
      tick();
      t++;
    end
    start = 1'b0; in_valid = 1'b0;
    check($sformatf("job%0d_done_seen", id), 64'(done_t >= 0), 64'd1);
    check($sformatf("job%0d_en_count", id), 64'(en_cnt), 64'(j.exp_en));
    if (j.exp_done > 0) check($sformatf("job%0d_done_cycle", id), 64'(done_t), 64'(j.exp_done));
    check($sformatf("job%0d_arr_clr_count", id), 64'(clr_cnt), 64'(j.k > 0));
    check($sformatf("job%0d_busy_after", id), 64'(busy), 64'd0);
    check($sformatf("job%0d_done_pulse", id), 64'(done), 64'd0);
    if (j.k > 0) begin
      check($sformatf("job%0d_done_after_en", id), 64'(done_t), 64'(last_en + 1));
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          s = '0;
          for (int kk = 0; kk < j.k; kk++) s = s + ma[r][kk] * mb[kk][c];
          check($sformatf("job%0d_C[%0d][%0d]", id, r, c), 64'(acc[r][c]), 64'(s));
        end
    end else begin
      check($sformatf("job%0d_in_ready_count", id), 64'(rdy_cnt), 64'd0);
    end
    if (j.fill == 0 && j.k == 1) begin
      for (int r = 0; r < 8; r++) begin
        check($sformatf("job%0d_a_lane%0d_hits", id, r), 64'(a_nz_cnt[r]), 64'd1);
        check($sformatf("job%0d_a_lane%0d_slot", id, r), 64'(a_nz_idx[r]), 64'(r));
        check($sformatf("job%0d_b_lane%0d_slot", id, r), 64'(b_nz_idx[r]), 64'(r));
      end
    end
  endtask

  job_t jobs [6];
  int   done_cnt;

  initial begin
    jobs[0] = '{k: 1,   stall: 0, glitch: 0, fill: 0, exp_en: 15,  exp_done: 17};
    jobs[1] = '{k: 8,   stall: 1, glitch: 0, fill: 1, exp_en: 22,  exp_done: -1};
    jobs[2] = '{k: 0,   stall: 0, glitch: 0, fill: 1, exp_en: 0,   exp_done: 1};
    jobs[3] = '{k: 5,   stall: 0, glitch: 1, fill: 1, exp_en: 19,  exp_done: 21};
    jobs[4] = '{k: 3,   stall: 2, glitch: 1, fill: 1, exp_en: 17,  exp_done: -1};
    jobs[5] = '{k: 255, stall: 0, glitch: 0, fill: 2, exp_en: 269, exp_done: 271};

    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_vec = '0; b_vec = '0;
    tick(); tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_en", 64'(en), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    tick();

    // Abort mid-FEED after three beats with an asynchronous reset between edges.
    start = 1'b1; k_len = 8'd8;
    tick();
    start = 1'b0;
    check("abort_arr_clr", 64'(arr_clr), 64'd1);
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; a_vec = {$urandom, $urandom} | 64'h0101_0101_0101_0101; b_vec = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    check("abort_en_before", 64'(en), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_en", 64'(en), 64'd0);
    check("abort_arr_clr_low", 64'(arr_clr), 64'd0);
    check("abort_a_flat", a_in_flat, 64'd0);
    check("abort_b_flat", b_in_flat, 64'd0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_job(jobs[i], i);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
